block_table: RTL
================

# block_table

Register-mapped store for the 15 on-screen Tetris block sprites. Provides the per-block origin, colour and bypass arrays consumed by the block sprite renderer. Software writes a shadow copy over the bus interface. A commit request copies the whole shadow set into the active set at the next frame boundary, so the renderer never sees a half-updated playfield within a frame.

## Interface
- NUM_BLOCKS, 15, number of block entries (renderer is built for 15)
- COORD_W, 11, x/y coordinate width
- COLOR_W, 3, colour code width (bit2=R, bit1=G, bit0=B)

- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- cs  in  1  bus chip select for this slot
- write  in  1  bus write strobe (qualified by cs)
- addr  in  5  word address
- wr_data  in  32  write data
- rd_data  out  32  registered read data
- frame_start  in  1  one-cycle pulse at start of vertical blanking, from the VGA sync stage
- xs  out  NUM_BLOCKS x COORD_W  active x origins
- ys  out  NUM_BLOCKS x COORD_W  active y origins
- color  out  NUM_BLOCKS x COLOR_W  active colour codes
- block_bypass  out  NUM_BLOCKS  active hide flags (1 = not drawn)
- commit_pending  out  1  commit requested, not yet applied

## Operation
- Entry word layout:
  - [10:0] x
  - [21:11] y
  - [24:22] color
  - [25] bypass
  - [31:26] ignored on write, read as 0
- Write map, cs&write:
  - addr 0..14 → shadow entry[addr] = fields.
  - addr 16 → control:
    - bit0=1 sets commit_pending.
    - bit1=1 sets bypass=1 in every shadow entry. Coordinates and colour are unchanged.
    - Both bits may be set in one write. The clear is applied to shadow in that cycle, and the clear's result is what a later commit copies.
  - addr 15, 17..31 → no effect.
- Read map, any cs (write or not) updates rd_data next cycle:
  - 0..14 → shadow entry.
  - 16 → {30'b0, 1'b0, commit_pending}.
  - 17 → {16'b0, commit_count[7:0], frame_count[7:0]}.
  - others → 0.
  - With cs=0, rd_data holds its value.
- Commit:
  - On frame_start with commit_pending=1 (registered value), all active entries are loaded from shadow in one cycle.
  - In the same cycle commit_pending clears and commit_count increments.
- frame_count increments on every frame_start. commit_count increments per applied commit. Both are 8-bit and wrap 255→0.
- Boundary rules:
  - Commit request write in the same cycle as frame_start: the frame_start sees the old pending value. If pending was 0, the request stays pending until the next frame_start. If pending was 1, the commit applies and pending stays 1, because the new request re-arms it.
  - Shadow entry write in the same cycle as frame_start commit: active gets the pre-write shadow value. The write lands in shadow only.
  - Repeated commit requests before frame_start: merged into one commit.
  - Shadow writes while pending: allowed, and included in the pending commit.
  - No frame_start ever: active never changes. Pending holds indefinitely.

## Timing
- Reset (async assert, synchronous deassert assumed from the top level) sets every shadow and active entry to x=0, y=0, color=0, bypass=1. Consequences:
  - block_bypass=15'h7FFF, xs/ys/color all 0
  - commit_pending=0
  - rd_data=0
  - both counters 0
- Write → shadow visible on read: a read issued the cycle after the write returns the new value. rd_data is valid 1 cycle after the read cycle.
- Commit request → commit_pending=1 the next cycle.
- frame_start edge (pending=1) → xs/ys/color/block_bypass show the new values from the next cycle, all entries simultaneously.
- Active outputs come straight from registers, with no combinational path from the bus.
- Reset asserted mid-operation: all state returns to reset values immediately. A pending commit is discarded.

## Structure
- Package block_table_pkg holds:
  - typedef block_entry_t (packed: bypass, color, y, x)
  - field LSB/width constants
  - ADDR_CTRL=16, ADDR_STAT=17
  - CTRL_COMMIT_BIT=0, CTRL_CLEAR_BIT=1
- Sub-module block_entry_reg: one shadow+active register pair, with inputs for write-enable, clear, load-active and data. Instantiated NUM_BLOCKS times. The top level handles decode, pending flag, counters and read mux.

## Test plan
- Reset release → block_bypass=7FFF, all xs/ys=0, rd_data=0. Read addr 17 → 0.
- Write addr 3 = {bypass0, color 3'b101, y=64, x=96}, no commit, several frame_starts → active entry 3 stays bypassed. Read addr 3 returns the written word. frame_count matches the pulse count.
- Same write, commit (addr16=1), frame_start → next cycle xs[3]=96, ys[3]=64, color[3]=5, block_bypass[3]=0, commit_pending=0, commit_count=1.
- Commit write coincident with frame_start while pending=0 → no change that frame. Applied at the next frame_start. Commit write while pending=1 with frame_start → applied, and pending stays 1.
- Entry 0 written with x=10 in the frame_start cycle of a pending commit → active xs[0] gets the old shadow x. Shadow reads back 10.
- Control write 0x3 after populating entries → next commit sets all block_bypass=1 with coordinates preserved. 256 frame_starts → frame_count wraps to 0.

Source files
------------

// File: rtl/block_table_pkg.sv
// block_table_pkg
// Shared types and constants for the block sprite register table.
//   - block_entry_t : packed entry {bypass, color, y, x}, bit-identical to
//                     the low 26 bits of the bus word
//   - field LSB/width constants, control/status addresses, control bits
//   - helpers converting between bus words and entries
package block_table_pkg;

  localparam int NUM_BLOCKS = 15;
  localparam int COORD_W    = 11;
  localparam int COLOR_W    = 3;

  localparam int X_LSB      = 0;
  localparam int Y_LSB      = 11;
  localparam int COLOR_LSB  = 22;
  localparam int BYPASS_BIT = 25;
  localparam int ENTRY_W    = 26;

  localparam logic [4:0] ADDR_LAST_ENTRY = 5'd14;
  localparam logic [4:0] ADDR_CTRL       = 5'd16;
  localparam logic [4:0] ADDR_STAT       = 5'd17;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;

  typedef struct packed {
    logic               bypass;
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } block_entry_t;

  // Reset value of every entry: parked at the origin and hidden.
  localparam block_entry_t ENTRY_RESET = '{bypass: 1'b1, color: 3'd0, y: 11'd0, x: 11'd0};

  // Bus word to entry; bits [31:26] are dropped.
  function automatic block_entry_t word_to_entry(input logic [31:0] word);
    return block_entry_t'(word[ENTRY_W-1:0]);
  endfunction

  // Entry to bus word; unused upper bits read as zero.
  function automatic logic [31:0] entry_to_word(input block_entry_t entry);
    return {6'd0, entry};
  endfunction

endpackage

// File: rtl/block_entry_reg.sv
// block_entry_reg
// One shadow/active register pair for a single block sprite.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   we           : load shadow from wdata
//   clr          : force shadow bypass to 1 (coordinates/colour kept)
//   load         : copy shadow into active (sees the pre-write shadow)
//   wdata        : new shadow contents
//   shadow       : shadow register (bus-visible copy)
//   active       : active register (renderer-visible copy)
module block_entry_reg
  import block_table_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         we,
  input  logic         clr,
  input  logic         load,
  input  block_entry_t wdata,
  output block_entry_t shadow,
  output block_entry_t active
);

  // Shadow copy: bus writes take priority over the global clear (the two
  // come from different addresses and never coincide).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= ENTRY_RESET;
    end else if (we) begin
      shadow <= wdata;
    end else if (clr) begin
      shadow.bypass <= 1'b1;
    end else begin
      shadow <= shadow;
    end
  end

  // Active copy: loaded from the current (pre-write) shadow on commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= ENTRY_RESET;
    end else if (load) begin
      active <= shadow;
    end else begin
      active <= active;
    end
  end

endmodule

// File: rtl/block_table.sv
// block_table
// Register-mapped store for the on-screen block sprites. Software edits a
// shadow set over the bus; a commit request copies the whole shadow set to
// the active set on the next frame_start, so the renderer never sees a
// partially updated playfield.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   cs, write, addr : bus select, write strobe, 5-bit word address
//   wr_data         : bus write data
//   rd_data         : registered read data (updates only when cs=1)
//   frame_start     : one-cycle pulse at start of vertical blanking
//   xs, ys, color   : active per-block origin and colour
//   block_bypass    : active per-block hide flags (1 = not drawn)
//   commit_pending  : commit requested, not yet applied
module block_table
  import block_table_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cs,
  input  logic                               write,
  input  logic [4:0]                         addr,
  input  logic [31:0]                        wr_data,
  output logic [31:0]                        rd_data,
  input  logic                               frame_start,
  output logic [NUM_BLOCKS-1:0][COORD_W-1:0] xs,
  output logic [NUM_BLOCKS-1:0][COORD_W-1:0] ys,
  output logic [NUM_BLOCKS-1:0][COLOR_W-1:0] color,
  output logic [NUM_BLOCKS-1:0]              block_bypass,
  output logic                               commit_pending
);

  logic                  bus_wr;
  logic                  ctrl_wr;
  logic                  clear_all;
  logic                  commit_fire;
  logic [NUM_BLOCKS-1:0] entry_we;
  block_entry_t          wr_entry;
  block_entry_t [NUM_BLOCKS-1:0] shadow;
  block_entry_t [NUM_BLOCKS-1:0] active;

  logic        pending_r;
  logic [7:0]  frame_count_r;
  logic [7:0]  commit_count_r;
  logic [31:0] rd_next;

  assign bus_wr      = cs && write;
  assign ctrl_wr     = bus_wr && (addr == ADDR_CTRL);
  assign clear_all   = ctrl_wr && wr_data[CTRL_CLEAR_BIT];
  // Uses the registered pending flag, so a request arriving with this
  // frame_start is not seen until the next one.
  assign commit_fire = frame_start && pending_r;
  assign wr_entry    = word_to_entry(wr_data);

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_entry
    assign entry_we[i] = bus_wr && (addr == 5'(i));

    block_entry_reg u_entry (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (entry_we[i]),
      .clr     (clear_all),
      .load    (commit_fire),
      .wdata   (wr_entry),
      .shadow  (shadow[i]),
      .active  (active[i])
    );

    assign xs[i]           = active[i].x;
    assign ys[i]           = active[i].y;
    assign color[i]        = active[i].color;
    assign block_bypass[i] = active[i].bypass;
  end

  assign commit_pending = pending_r;

  // Pending flag: a new request wins over the clear from a commit in the
  // same cycle, which re-arms it for the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= 1'b0;
    end else if (ctrl_wr && wr_data[CTRL_COMMIT_BIT]) begin
      pending_r <= 1'b1;
    end else if (commit_fire) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Frame and commit counters, both free-running 8-bit wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_r  <= 8'd0;
      commit_count_r <= 8'd0;
    end else begin
      frame_count_r  <= frame_start ? frame_count_r + 8'd1 : frame_count_r;
      commit_count_r <= commit_fire ? commit_count_r + 8'd1 : commit_count_r;
    end
  end

  // Read mux over shadow entries, control and status words.
  always_comb begin
    rd_next = 32'd0;
    if (addr <= ADDR_LAST_ENTRY) begin
      rd_next = entry_to_word(shadow[addr[3:0]]);
    end else begin
      case (addr)
        ADDR_CTRL: rd_next = {31'd0, pending_r};
        ADDR_STAT: rd_next = {16'd0, commit_count_r, frame_count_r};
        default:   rd_next = 32'd0;
      endcase
    end
  end

  // Read data register; holds its value while not selected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= 32'd0;
    end else if (cs) begin
      rd_data <= rd_next;
    end else begin
      rd_data <= rd_data;
    end
  end

endmodule
